// File: rtl/idct_vecrot_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : idct_vecrot_ctrl_pkg
// Brief    : Shared types and frame-size helpers for the IDCT vector-rotation
//            frame sequencer.
// Revision : 1.0
// ============================================================================
package idct_vecrot_ctrl_pkg;

    localparam int C_PTS_W     = 12;
    localparam int C_NUM_LEGAL = 7;
    localparam logic [C_PTS_W-1:0] C_LEGAL_PTS [C_NUM_LEGAL] = '{
        12'd32, 12'd64, 12'd128, 12'd256, 12'd512, 12'd1024, 12'd2048
    };

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ROT   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    function automatic logic is_legal_pts(input logic [C_PTS_W-1:0] n);
        logic r;
        r = 1'b0;
        for (int i = 0; i < C_NUM_LEGAL; i++) begin
            if (n == C_LEGAL_PTS[i]) r = 1'b1;
        end
        return r;
    endfunction

    // Coefficient step is 2048/N, returned as a shift amount (2048 -> 0, 32 -> 6).
    function automatic logic [2:0] log2_step(input logic [C_PTS_W-1:0] n);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < C_NUM_LEGAL; i++) begin
            if (n == C_LEGAL_PTS[i]) s = 3'(C_NUM_LEGAL - 1 - i);
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idct_vecrot_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : idct_vecrot_ctrl_if
// Brief    : Sink, buffer, coefficient ROM and source signals of the sequencer.
// Revision : 1.0
// ============================================================================
interface idct_vecrot_ctrl_if #(
    parameter int W_ADDR = 11
);
    logic [11:0]       fftpts_in;
    logic              sink_valid;
    logic              sink_sop;
    logic              sink_eop;
    logic              sink_ready;
    logic              fft_ready;
    logic              buf_wr_en;
    logic [W_ADDR-1:0] buf_wr_addr;
    logic              buf_rd_en;
    logic [W_ADDR-1:0] buf_rd_addr_a;
    logic [W_ADDR-1:0] buf_rd_addr_b;
    logic [W_ADDR-1:0] coeff_addr;
    logic              source_valid;
    logic              source_sop;
    logic              source_eop;
    logic              error;

    modport master (
        output fftpts_in, sink_valid, sink_sop, sink_eop, fft_ready,
        input  sink_ready, buf_wr_en, buf_wr_addr, buf_rd_en, buf_rd_addr_a,
               buf_rd_addr_b, coeff_addr, source_valid, source_sop, source_eop, error
    );

    modport slave (
        input  fftpts_in, sink_valid, sink_sop, sink_eop, fft_ready,
        output sink_ready, buf_wr_en, buf_wr_addr, buf_rd_en, buf_rd_addr_a,
               buf_rd_addr_b, coeff_addr, source_valid, source_sop, source_eop, error
    );
endinterface
`default_nettype wire

// File: rtl/idct_vecrot_ctrl_strobe_dly.sv
`default_nettype none
// ============================================================================
// Module   : idct_strobe_dly
// Brief    : Resettable fixed-depth delay line; DEPTH 0 is a plain wire.
// Revision : 1.0
// ============================================================================
module idct_strobe_dly #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign o_q = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/idct_vecrot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : idct_vecrot_ctrl
// Brief    : Loads one frame into the input buffer, then replays it as (k, N-k)
//            pairs with matching coefficient ROM addresses and source strobes.
// Revision : 1.0
// ============================================================================
module idct_vecrot_ctrl
    import idct_vecrot_ctrl_pkg::*;
#(
    parameter int W_ADDR  = 11,
    parameter int RD_LAT  = 2,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_sync,
    idct_vecrot_ctrl_if.slave bus
);

    localparam logic [W_ADDR-1:0] C_DRAIN_LAST = W_ADDR'(RD_LAT - 1);

    state_t            r_state,  w_state_nxt;
    logic [W_ADDR-1:0] r_cnt,    w_cnt_nxt;
    logic [W_ADDR-1:0] r_mask,   w_mask_nxt;
    logic [2:0]        r_shift,  w_shift_nxt;
    logic              r_error,  w_error_nxt;

    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_sink_ready;
    logic              w_last;
    logic [W_ADDR-1:0] w_pts_mask;
    logic [W_ADDR-1:0] w_coeff_issue;
    logic [2:0]        w_src_q;

    // N is a power of two, so N-1 doubles as the wrap mask for (N-k) mod N.
    assign w_pts_mask = bus.fftpts_in[W_ADDR-1:0] - W_ADDR'(1);
    assign w_last     = (r_cnt == r_mask);

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_shift <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mask  <= w_mask_nxt;
            r_shift <= w_shift_nxt;
            r_error <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_mask_nxt   = r_mask;
        w_shift_nxt  = r_shift;
        w_error_nxt  = r_error;
        w_wr_en      = 1'b0;
        w_rd_en      = 1'b0;
        w_sink_ready = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_sink_ready = 1'b1;
                if (bus.sink_valid && bus.sink_sop) begin
                    // A one-sample frame is never legal, so sop+eop here is an early eop.
                    if (!is_legal_pts(bus.fftpts_in) || bus.sink_eop) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_mask_nxt  = w_pts_mask;
                        w_shift_nxt = log2_step(bus.fftpts_in);
                        w_cnt_nxt   = W_ADDR'(1);
                        w_state_nxt = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                w_sink_ready = 1'b1;
                if (bus.sink_valid) begin
                    if (bus.sink_sop || (bus.sink_eop != w_last)) begin
                        w_error_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_wr_en = 1'b1;
                        if (bus.sink_eop) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_WAIT;
                        end else begin
                            w_cnt_nxt = r_cnt + W_ADDR'(1);
                        end
                    end
                end
            end

            ST_WAIT: begin
                if (bus.fft_ready) w_state_nxt = ST_ROT;
            end

            ST_ROT: begin
                w_rd_en = 1'b1;
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + W_ADDR'(1);
                end
            end

            ST_DRAIN: begin
                if (r_cnt == C_DRAIN_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + W_ADDR'(1);
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_coeff_issue = w_rd_en ? (r_cnt << r_shift) : '0;

    assign bus.sink_ready    = w_sink_ready;
    assign bus.buf_wr_en     = w_wr_en;
    assign bus.buf_wr_addr   = w_wr_en ? r_cnt : '0;
    assign bus.buf_rd_en     = w_rd_en;
    assign bus.buf_rd_addr_a = w_rd_en ? r_cnt : '0;
    assign bus.buf_rd_addr_b = w_rd_en ? ((W_ADDR'(0) - r_cnt) & r_mask) : '0;
    assign bus.error         = r_error;

    idct_strobe_dly #(
        .WIDTH (3),
        .DEPTH (RD_LAT)
    ) u_src_dly (
        .clk (clk),
        .rst (rst_sync),
        .i_d ({w_rd_en, w_rd_en & (r_cnt == '0), w_rd_en & w_last}),
        .o_q (w_src_q)
    );

    assign bus.source_valid = w_src_q[2];
    assign bus.source_sop   = w_src_q[1];
    assign bus.source_eop   = w_src_q[0];

    // ROM is faster than the buffer; hold its address back so q lands with buffer data.
    idct_strobe_dly #(
        .WIDTH (W_ADDR),
        .DEPTH (RD_LAT - ROM_LAT)
    ) u_coeff_dly (
        .clk (clk),
        .rst (rst_sync),
        .i_d (w_coeff_issue),
        .o_q (bus.coeff_addr)
    );

endmodule
`default_nettype wire

// File: tb/tb_idct_vecrot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_idct_vecrot_ctrl
// Brief    : Scoreboard bench for the IDCT vector-rotation frame sequencer.
// Revision : 1.0
// ============================================================================
module tb_idct_vecrot_ctrl;

    localparam int W_ADDR  = 11;
    localparam int RD_LAT  = 2;
    localparam int ROM_LAT = 1;

    typedef struct {int k; int a; int b; int c; bit sop; bit eop;} rd_exp_t;
    typedef struct {int due; int val;} coef_exp_t;
    typedef struct {int due; bit sop; bit eop;} src_exp_t;

    logic clk = 1'b0;
    logic rst_sync;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_start = -1;
    int   last_rd_cyc = -10;
    bit   wr_dontcare = 1'b0;

    int        wr_q[$];
    rd_exp_t   rd_q[$];
    coef_exp_t coef_q[$];
    src_exp_t  src_q[$];

    int        m_wr;
    rd_exp_t   m_rd;
    coef_exp_t m_coef;
    src_exp_t  m_src;

    idct_vecrot_ctrl_if #(.W_ADDR(W_ADDR)) bus ();

    idct_vecrot_ctrl #(
        .W_ADDR  (W_ADDR),
        .RD_LAT  (RD_LAT),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk      (clk),
        .rst_sync (rst_sync),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference replay of a frame: pair (k, N-k mod N), coefficient k*2048/N.
    task automatic push_reads(input int n);
        for (int k = 0; k < n; k++) begin
            rd_q.push_back('{k, k, (n - k) % n, k * (2048 / n), k == 0, k == n - 1});
        end
    endtask

    always @(negedge clk) begin
        if (bus.buf_wr_en && !wr_dontcare) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", int'(bus.buf_wr_en), 0);
            end else begin
                m_wr = wr_q.pop_front();
                chk("wr_addr", int'(bus.buf_wr_addr), m_wr);
            end
        end
        if (bus.buf_rd_en) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", int'(bus.buf_rd_en), 0);
            end else begin
                m_rd = rd_q.pop_front();
                chk("rd_addr_a", int'(bus.buf_rd_addr_a), m_rd.a);
                chk("rd_addr_b", int'(bus.buf_rd_addr_b), m_rd.b);
                if (m_rd.k == 0) chk("rot_start_cycle", cyc, exp_start);
                else             chk("rot_gap", cyc - last_rd_cyc, 1);
                last_rd_cyc = cyc;
                coef_q.push_back('{cyc + RD_LAT - ROM_LAT, m_rd.c});
                src_q.push_back('{cyc + RD_LAT, m_rd.sop, m_rd.eop});
            end
        end
        if (coef_q.size() > 0 && coef_q[0].due == cyc) begin
            m_coef = coef_q.pop_front();
            chk("coeff_addr", int'(bus.coeff_addr), m_coef.val);
        end
        if (bus.source_valid) begin
            if (src_q.size() == 0) begin
                chk("src_unexpected", int'(bus.source_valid), 0);
            end else begin
                m_src = src_q.pop_front();
                chk("src_cycle", cyc, m_src.due);
                chk("source_sop", int'(bus.source_sop), int'(m_src.sop));
                chk("source_eop", int'(bus.source_eop), int'(m_src.eop));
            end
        end else if (src_q.size() > 0 && src_q[0].due <= cyc) begin
            m_src = src_q.pop_front();
            chk("src_missing", int'(bus.source_valid), 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input int hold, input int exp_accept,
                              input int eop_at, input bit gaps);
        int t;
        int eop_cyc;
        if (hold > 0) bus.fft_ready = 1'b0;
        bus.sink_valid = 1'b1;
        bus.sink_sop   = 1'b1;
        bus.sink_eop   = 1'b0;
        bus.fftpts_in  = 12'(n);
        t = 0;
        while (!bus.sink_ready && t < 20000) begin
            tick();
            t++;
        end
        chk("sop_accept_ready", int'(bus.sink_ready), 1);
        if (exp_accept >= 0) chk("sop_accept_cycle", cyc, exp_accept);
        wr_q.push_back(0);
        for (int i = 1; i <= eop_at; i++) begin
            tick();
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.sink_valid = 1'b0;
                bus.sink_sop   = 1'($urandom_range(0, 1));
                bus.sink_eop   = 1'($urandom_range(0, 1));
                bus.fftpts_in  = 12'($urandom_range(0, 4095));
                tick();
            end
            bus.sink_valid = 1'b1;
            bus.sink_sop   = 1'b0;
            bus.sink_eop   = (i == eop_at);
            bus.fftpts_in  = 12'($urandom_range(0, 4095));
            if (i == eop_at && eop_at != n - 1) wr_dontcare = 1'b1;
            else                                wr_q.push_back(i);
        end
        eop_cyc = cyc;
        tick();
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        bus.sink_eop   = 1'b0;
        wr_dontcare    = 1'b0;
        if (eop_at == n - 1) begin
            if (hold > 0) begin
                repeat (hold) tick();
                bus.fft_ready = 1'b1;
                exp_start = cyc + 1;
            end else begin
                exp_start = eop_cyc + 2;
            end
            push_reads(n);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(bus.sink_ready && rd_q.size() == 0 && src_q.size() == 0 &&
                 coef_q.size() == 0 && wr_q.size() == 0) && t < 20000) begin
            tick();
            t++;
        end
        chk("idle_ready", int'(bus.sink_ready), 1);
        chk("queues_drained", rd_q.size() + src_q.size() + coef_q.size() + wr_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sink_ready"},   int'(bus.sink_ready), 1);
        chk({tag, "_buf_wr_en"},    int'(bus.buf_wr_en), 0);
        chk({tag, "_buf_wr_addr"},  int'(bus.buf_wr_addr), 0);
        chk({tag, "_buf_rd_en"},    int'(bus.buf_rd_en), 0);
        chk({tag, "_rd_addr_a"},    int'(bus.buf_rd_addr_a), 0);
        chk({tag, "_rd_addr_b"},    int'(bus.buf_rd_addr_b), 0);
        chk({tag, "_coeff_addr"},   int'(bus.coeff_addr), 0);
        chk({tag, "_source_valid"}, int'(bus.source_valid), 0);
        chk({tag, "_source_sop"},   int'(bus.source_sop), 0);
        chk({tag, "_source_eop"},   int'(bus.source_eop), 0);
        chk({tag, "_error"},        int'(bus.error), 0);
    endtask

    task automatic do_reset();
        rst_sync = 1'b1;
        tick();
        wr_q.delete();
        rd_q.delete();
        coef_q.delete();
        src_q.delete();
        chk_reset_outputs("rst");
        rst_sync = 1'b0;
    endtask

    initial begin
        int t;
        int n;
        rst_sync       = 1'b1;
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        bus.sink_eop   = 1'b0;
        bus.fftpts_in  = 12'd0;
        bus.fft_ready  = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("por");
        rst_sync = 1'b0;
        tick();

        // Smallest frame, contiguous samples.
        send_frame(32, 0, -1, 31, 1'b0);
        wait_idle();

        // Largest frame twice back to back; second sop waits out DRAIN.
        send_frame(2048, 0, -1, 2047, 1'b0);
        send_frame(2048, 0, exp_start + 2048 + RD_LAT, 2047, 1'b0);
        wait_idle();

        // Downstream not ready for 10 clocks after eop.
        send_frame(64, 10, -1, 63, 1'b0);
        wait_idle();

        for (int f = 0; f < 4; f++) begin
            n = 32 << $urandom_range(0, 3);
            send_frame(n, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0,
                       -1, n - 1, 1'b1);
            wait_idle();
        end

        // Illegal frame size.
        bus.sink_valid = 1'b1;
        bus.sink_sop   = 1'b1;
        bus.fftpts_in  = 12'd100;
        tick();
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        chk("illegal_error", int'(bus.error), 1);
        chk("illegal_idle", int'(bus.sink_ready), 1);
        repeat (5) tick();
        chk("illegal_error_sticky", int'(bus.error), 1);
        do_reset();

        // Early eop at sample 40 of a 64-point frame.
        send_frame(64, 0, -1, 40, 1'b0);
        chk("early_eop_error", int'(bus.error), 1);
        chk("early_eop_idle", int'(bus.sink_ready), 1);
        repeat (20) tick();
        do_reset();

        // Reset while k=17 of a 256-point frame is being issued.
        send_frame(256, 0, -1, 255, 1'b1);
        t = 0;
        while (cyc < exp_start + 17 && t < 5000) begin
            tick();
            t++;
        end
        chk("midrot_in_rot", int'(bus.buf_rd_en), 1);
        chk("midrot_k", int'(bus.buf_rd_addr_a), 17);
        do_reset();
        tick();
        send_frame(32, 0, -1, 31, 1'b1);
        wait_idle();
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
